// File: rtl/axi_store_pkg.sv
// axi_store_pkg: shared constants, store encodings and the size-to-byte-mask helper
// for the AXI store unit.
`default_nettype none

package axi_store_pkg;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic [2:0] {
      F3_SB = 3'b000,
      F3_SH = 3'b001,
      F3_SW = 3'b010,
      F3_SD = 3'b011
   } store_funct3_e;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   function automatic logic [7:0] size_mask(input logic [1:0] size);
      logic [7:0] mask;
      case (size)
         2'd0:    mask = 8'h01;
         2'd1:    mask = 8'h03;
         2'd2:    mask = 8'h0F;
         default: mask = 8'hFF;
      endcase
      return mask;
   endfunction

endpackage

`default_nettype wire

// File: rtl/store_lane_gen.sv
// store_lane_gen: places LSB-aligned store data onto the byte lanes selected by the
// low address bits, and produces the matching strobe and a misalignment flag.
`default_nettype none

module store_lane_gen
   import axi_store_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic [2:0]            funct3,
   input  logic [2:0]            offset,
   input  logic [DATA_WIDTH-1:0] data,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic [STRB_WIDTH-1:0] wstrb,
   output logic                  misaligned
);

   logic [STRB_WIDTH+7:0] strb_wide;

   always_comb begin
      strb_wide = {{STRB_WIDTH{1'b0}}, size_mask(funct3[1:0])} << offset;
      wstrb     = strb_wide[STRB_WIDTH-1:0];
      wdata     = data << {offset, 3'b000};
   end

   always_comb begin
      misaligned = 1'b0;
      case (funct3[1:0])
         2'd1:    misaligned = offset[0];
         2'd2:    misaligned = |offset[1:0];
         2'd3:    misaligned = |offset;
         default: misaligned = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/axi_store_unit.sv
// axi_store_unit: issues one single-beat AXI4 write per store request (SB/SH/SW/SD)
// and reports completion with an error flag.
`default_nettype none

module axi_store_unit
   import axi_store_pkg::*;
#(
   parameter int                  ID_WIDTH   = 13,
   parameter int                  ADDR_WIDTH = 64,
   parameter int                  DATA_WIDTH = 64,
   parameter int                  STRB_WIDTH = DATA_WIDTH / 8,
   parameter logic [ID_WIDTH-1:0] STORE_ID   = 13'h0001
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  st_valid,
   output logic                  st_ready,
   input  logic [ADDR_WIDTH-1:0] st_addr,
   input  logic [DATA_WIDTH-1:0] st_data,
   input  logic [2:0]            st_funct3,
   output logic                  st_done,
   output logic                  st_err,

   output logic [ID_WIDTH-1:0]   m_axi_awid,
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [7:0]            m_axi_awlen,
   output logic [2:0]            m_axi_awsize,
   output logic [1:0]            m_axi_awburst,
   output logic                  m_axi_awlock,
   output logic [3:0]            m_axi_awcache,
   output logic [2:0]            m_axi_awprot,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,

   output logic [DATA_WIDTH-1:0] m_axi_wdata,
   output logic [STRB_WIDTH-1:0] m_axi_wstrb,
   output logic                  m_axi_wlast,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,

   input  logic [ID_WIDTH-1:0]   m_axi_bid,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready
);

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] awaddr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_WIDTH-1:0] wstrb_q;
   logic [1:0]            size_q;
   logic                  awvalid_q;
   logic                  wvalid_q;
   logic                  err_q;

   logic [DATA_WIDTH-1:0] lane_wdata;
   logic [STRB_WIDTH-1:0] lane_wstrb;
   logic                  lane_misaligned;
   logic                  reject;
   logic                  aw_clear;
   logic                  w_clear;

   store_lane_gen #(
      .DATA_WIDTH (DATA_WIDTH),
      .STRB_WIDTH (STRB_WIDTH)
   ) u_lane_gen (
      .funct3     (st_funct3),
      .offset     (st_addr[2:0]),
      .data       (st_data),
      .wdata      (lane_wdata),
      .wstrb      (lane_wstrb),
      .misaligned (lane_misaligned)
   );

   assign reject   = st_funct3[2] | lane_misaligned;
   // A channel is finished once its valid is low or is being accepted this cycle.
   assign aw_clear = !awvalid_q || m_axi_awready;
   assign w_clear  = !wvalid_q  || m_axi_wready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         size_q    <= 2'd0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (st_valid) begin
                  awaddr_q <= st_addr;
                  wdata_q  <= lane_wdata;
                  wstrb_q  <= lane_wstrb;
                  size_q   <= st_funct3[1:0];
                  if (reject) begin
                     err_q <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     err_q     <= 1'b0;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state     <= ST_SEND;
                  end
               end
            end
            ST_SEND: begin
               if (awvalid_q && m_axi_awready) awvalid_q <= 1'b0;
               if (wvalid_q && m_axi_wready)   wvalid_q  <= 1'b0;
               if (aw_clear && w_clear)        state     <= ST_RESP;
            end
            ST_RESP: begin
               if (m_axi_bvalid) begin
                  err_q <= (m_axi_bresp != AXI_RESP_OKAY) || (m_axi_bid != STORE_ID);
                  state <= ST_DONE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign st_ready      = (state == ST_IDLE);
   assign st_done       = (state == ST_DONE);
   assign st_err        = st_done && err_q;

   assign m_axi_awid    = STORE_ID;
   assign m_axi_awaddr  = awaddr_q;
   assign m_axi_awlen   = 8'd0;
   assign m_axi_awsize  = {1'b0, size_q};
   assign m_axi_awburst = AXI_BURST_INCR;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awcache = 4'b0011;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awvalid = awvalid_q;

   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_wlast   = wvalid_q;
   assign m_axi_wvalid  = wvalid_q;

   assign m_axi_bready  = (state == ST_RESP);

endmodule

`default_nettype wire

// File: tb/tb_axi_store_unit.sv
// tb_axi_store_unit: directed vectors with hand-computed expectations for axi_store_unit.
`default_nettype none

module tb_axi_store_unit;

   logic        clk;
   logic        reset;
   logic        st_valid;
   logic        st_ready;
   logic [63:0] st_addr;
   logic [63:0] st_data;
   logic [2:0]  st_funct3;
   logic        st_done;
   logic        st_err;
   logic [12:0] awid;
   logic [63:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [12:0] bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   int checks = 0;
   int errors = 0;

   axi_store_unit dut (
      .clk           (clk),
      .reset         (reset),
      .st_valid      (st_valid),
      .st_ready      (st_ready),
      .st_addr       (st_addr),
      .st_data       (st_data),
      .st_funct3     (st_funct3),
      .st_done       (st_done),
      .st_err        (st_err),
      .m_axi_awid    (awid),
      .m_axi_awaddr  (awaddr),
      .m_axi_awlen   (awlen),
      .m_axi_awsize  (awsize),
      .m_axi_awburst (awburst),
      .m_axi_awlock  (awlock),
      .m_axi_awcache (awcache),
      .m_axi_awprot  (awprot),
      .m_axi_awvalid (awvalid),
      .m_axi_awready (awready),
      .m_axi_wdata   (wdata),
      .m_axi_wstrb   (wstrb),
      .m_axi_wlast   (wlast),
      .m_axi_wvalid  (wvalid),
      .m_axi_wready  (wready),
      .m_axi_bid     (bid),
      .m_axi_bresp   (bresp),
      .m_axi_bvalid  (bvalid),
      .m_axi_bready  (bready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives a request for exactly one acceptance edge (unit must be idle).
   task automatic issue(input logic [63:0] addr, input logic [63:0] data, input logic [2:0] f3);
      st_valid  = 1'b1;
      st_addr   = addr;
      st_data   = data;
      st_funct3 = f3;
      tick();
      st_valid  = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      st_valid = 1'b0;
      st_addr  = '0;
      st_data  = '0;
      st_funct3 = 3'b000;
      awready  = 1'b1;
      wready   = 1'b1;
      bvalid   = 1'b0;
      bid      = 13'h0001;
      bresp    = 2'b00;

      tick();
      tick();
      check("rst_st_ready", {63'd0, st_ready}, 64'd1);
      check("rst_st_done",  {63'd0, st_done},  64'd0);
      check("rst_st_err",   {63'd0, st_err},   64'd0);
      check("rst_valids",   {61'd0, awvalid, wvalid, bready}, 64'd0);
      check("rst_awaddr",   awaddr, 64'd0);
      check("rst_wdata",    wdata,  64'd0);
      check("rst_wstrb",    {56'd0, wstrb}, 64'd0);

      // SD, all ready: accepted on the first edge after reset release
      reset  = 1'b0;
      bvalid = 1'b1;
      issue(64'h8000_0010, 64'h1122_3344_5566_7788, 3'b011);
      check("sd_awvalid", {63'd0, awvalid}, 64'd1);
      check("sd_wvalid",  {63'd0, wvalid},  64'd1);
      check("sd_awaddr",  awaddr, 64'h8000_0010);
      check("sd_wdata",   wdata,  64'h1122_3344_5566_7788);
      check("sd_wstrb",   {56'd0, wstrb}, 64'hFF);
      check("sd_awsize",  {61'd0, awsize}, 64'd3);
      check("sd_attrs",   {awid, awlen, awburst, awlock, awcache, awprot, wlast},
            {13'h0001, 8'd0, 2'b01, 1'b0, 4'b0011, 3'b000, 1'b1});
      check("sd_ready_busy", {63'd0, st_ready}, 64'd0);
      check("sd_done_c1", {63'd0, st_done}, 64'd0);
      tick();
      check("sd_bready",  {63'd0, bready}, 64'd1);
      check("sd_valids_low", {62'd0, awvalid, wvalid}, 64'd0);
      check("sd_done_c2", {63'd0, st_done}, 64'd0);
      tick();
      check("sd_done_c3", {63'd0, st_done}, 64'd1);
      check("sd_err",     {63'd0, st_err},  64'd0);
      check("sd_bready_done", {63'd0, bready}, 64'd0);
      tick();
      check("sd_done_pulse", {63'd0, st_done}, 64'd0);
      check("sd_idle", {63'd0, st_ready}, 64'd1);

      // SB at byte 5
      issue(64'h8000_0005, 64'h0000_0000_0000_00AB, 3'b000);
      check("sb_wdata",  wdata, 64'h0000_AB00_0000_0000);
      check("sb_wstrb",  {56'd0, wstrb}, 64'h20);
      check("sb_awsize", {61'd0, awsize}, 64'd0);
      tick();
      tick();
      check("sb_done", {62'd0, st_done, st_err}, 64'd2);
      tick();

      // Misaligned SW: no bus activity, done next cycle with error
      issue(64'h8000_0006, 64'h0000_0000_DEAD_BEEF, 3'b010);
      check("sw_mis_valids", {62'd0, awvalid, wvalid}, 64'd0);
      check("sw_mis_done",   {62'd0, st_done, st_err}, 64'd3);
      tick();
      check("sw_mis_idle", {63'd0, st_ready}, 64'd1);

      // Illegal funct3
      issue(64'h8000_0000, 64'h1, 3'b100);
      check("ill_f3_valids", {62'd0, awvalid, wvalid}, 64'd0);
      check("ill_f3_done",   {62'd0, st_done, st_err}, 64'd3);
      tick();

      // SH with awready held off for 4 cycles, wready immediate
      awready = 1'b0;
      bvalid  = 1'b0;
      issue(64'h0000_1002, 64'h0000_0000_0000_1234, 3'b001);
      check("sh_wdata", wdata, 64'h0000_0000_1234_0000);
      check("sh_wstrb", {56'd0, wstrb}, 64'h0C);
      for (int i = 0; i < 4; i++) begin
         check("sh_awvalid_hold", {63'd0, awvalid}, 64'd1);
         check("sh_awaddr_hold",  awaddr, 64'h0000_1002);
         check("sh_wvalid",       {63'd0, wvalid}, (i == 0) ? 64'd1 : 64'd0);
         check("sh_bready_wait",  {63'd0, bready}, 64'd0);
         tick();
      end
      awready = 1'b1;
      check("sh_awvalid_last", {63'd0, awvalid}, 64'd1);
      tick();
      check("sh_aw_done", {63'd0, awvalid}, 64'd0);
      check("sh_bready",  {63'd0, bready},  64'd1);
      tick();
      check("sh_wait_b", {62'd0, st_done, bready}, 64'd1);
      bvalid = 1'b1;
      tick();
      bvalid = 1'b0;
      check("sh_done", {62'd0, st_done, st_err}, 64'd2);
      tick();

      // SLVERR response, then a following request must still be accepted
      bvalid = 1'b1;
      bresp  = 2'b10;
      issue(64'h8000_0008, 64'h0000_0000_CAFE_F00D, 3'b010);
      check("slverr_wstrb", {56'd0, wstrb}, 64'h0F);
      tick();
      tick();
      check("slverr_done", {62'd0, st_done, st_err}, 64'd3);
      bresp = 2'b00;
      tick();
      check("slverr_idle", {63'd0, st_ready}, 64'd1);
      issue(64'h8000_0001, 64'h0000_0000_0000_0055, 3'b000);
      check("after_err_awvalid", {63'd0, awvalid}, 64'd1);
      check("after_err_wstrb",   {56'd0, wstrb}, 64'h02);
      tick();
      tick();
      check("after_err_done", {62'd0, st_done, st_err}, 64'd2);
      tick();

      // Wrong bid flags an error even with OKAY
      bid = 13'h0005;
      issue(64'h8000_0000, 64'h0, 3'b011);
      tick();
      tick();
      check("bid_err_done", {62'd0, st_done, st_err}, 64'd3);
      bid = 13'h0001;
      tick();

      // Asynchronous reset while waiting for the response
      bvalid = 1'b0;
      issue(64'h8000_0020, 64'h0123_4567_89AB_CDEF, 3'b011);
      tick();
      check("rstmid_bready_before", {63'd0, bready}, 64'd1);
      #2;
      reset = 1'b1;
      #1;
      check("rstmid_bready",   {63'd0, bready},   64'd0);
      check("rstmid_awvalid",  {63'd0, awvalid},  64'd0);
      check("rstmid_st_ready", {63'd0, st_ready}, 64'd1);
      check("rstmid_awaddr",   awaddr, 64'd0);
      bvalid = 1'b1;
      tick();
      check("rstmid_no_done", {63'd0, st_done}, 64'd0);
      reset  = 1'b0;
      bvalid = 1'b0;
      tick();
      check("rstmid_no_done2", {63'd0, st_done}, 64'd0);
      issue(64'h8000_0004, 64'h0000_0000_0000_0077, 3'b010);
      check("rstmid_next_wdata", wdata, 64'h0000_0077_0000_0000);
      check("rstmid_next_wstrb", {56'd0, wstrb}, 64'hF0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/axi_store_unit.md
AXI_STORE_UNIT -- requirements
Module: axi_store_unit

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 13, AXI ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, AXI address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, AXI data width; STRB_WIDTH = DATA_WIDTH/8.
REQ-004 SHALL have parameter STORE_ID, default 13'h0001, constant awid value.
REQ-005 SHALL use one clock, clk; reset is asynchronous and active-high, named reset.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 st_valid  in  1  store request valid.
REQ-009 st_ready  out  1  unit idle and accepts a request.
REQ-010 st_addr  in  ADDR_WIDTH  byte address.
REQ-011 st_data  in  DATA_WIDTH  store data, LSB-aligned.
REQ-012 st_funct3  in  3  000 SB, 001 SH, 010 SW, 011 SD.
REQ-013 st_done  out  1  one-cycle completion pulse.
REQ-014 st_err  out  1  qualifies st_done: misaligned address, illegal funct3, or non-OKAY bresp.
REQ-015 m_axi_aw{id,addr,len,size,burst,lock,cache,prot,valid} out / m_axi_awready in, widths per AXI4.
REQ-016 m_axi_w{data,strb,last,valid} out / m_axi_wready in.
REQ-017 m_axi_b{id,resp,valid} in / m_axi_bready out.

Function
REQ-018 States: IDLE, SEND, RESP, DONE; st_ready=1 only in IDLE.
REQ-019 IDLE: st_valid=1 latches addr/data/funct3; legal and aligned -> SEND, otherwise -> DONE with err=1 and no bus activity.
REQ-020 Alignment: SH requires addr[0]=0; SW requires addr[1:0]=0; SD requires addr[2:0]=0; funct3[2]=1 is illegal.
REQ-021 SEND entry: awvalid=1 and wvalid=1 in the same cycle, one cycle after acceptance.
REQ-022 awvalid drops the cycle after awready=1, wvalid drops the cycle after wready=1; the two handshakes complete independently in either order or together.
REQ-023 awaddr, wdata, and wstrb SHALL hold stable while their valid is high.
REQ-024 Both handshakes done -> RESP with bready=1.
REQ-025 bready is 0 outside RESP.
REQ-026 RESP: bvalid=1 -> DONE; err = (bresp != 2'b00) or (bid != STORE_ID).
REQ-027 DONE: st_done=1 for exactly one cycle, st_err as computed -> IDLE.
REQ-028 Minimum latency, acceptance to st_done, is 3 cycles when awready=wready=bvalid=1 immediately.
REQ-029 awlen=0; awsize=funct3[1:0]; awburst=2'b01 INCR; awlock=0; awcache=4'b0011; awprot=3'b000; wlast=1 whenever wvalid=1.
REQ-030 awaddr = st_addr unmodified.
REQ-031 wdata = st_data << (8*addr[2:0]).
REQ-032 wstrb = size mask (SB 0x01, SH 0x03, SW 0x0F, SD 0xFF) << addr[2:0].
REQ-033 st_valid is ignored outside IDLE; exactly one transaction is outstanding at a time.
REQ-034 bvalid arriving outside RESP is ignored, because bready=0.

Reset
REQ-035 Asserting reset forces IDLE immediately, including mid-transaction; any pending AXI transfer is abandoned.
REQ-036 Reset values: st_ready=1 (in IDLE); st_done=0, st_err=0, awvalid=0, wvalid=0, bready=0; awaddr, wdata, wstrb all zero.
REQ-037 The first request is accepted on the first rising clk edge after reset deasserts.

Structure
REQ-038 Shared package axi_store_pkg SHALL hold the state enum, funct3 store encodings, the AXI burst/resp constants (INCR, OKAY), and the size-to-mask function.
REQ-039 Single sub-module store_lane_gen (combinational): funct3 + addr[2:0] + data -> wdata, wstrb, misaligned flag.
REQ-040 RTL target is 120-400 lines.

Verification
REQ-041 SD addr 0x8000_0010 data 0x1122334455667788, all readys 1 -> wstrb 0xFF, awsize 3, st_done after 3 cycles, err 0.
REQ-042 SB addr 0x8000_0005 data 0xAB -> wdata 0x0000_AB00_0000_0000, wstrb 0x20, awsize 0.
REQ-043 SW addr 0x8000_0006 -> no awvalid/wvalid, st_done next cycle with st_err=1.
REQ-044 awready delayed 4 cycles, wready immediate -> wvalid drops after 1 cycle; awvalid and awaddr held stable; bready only after AW completes.
REQ-045 bresp=2'b10 (SLVERR) -> st_done with st_err=1; next request accepted in IDLE.
REQ-046 reset asserted during RESP -> bready=0, awvalid=0, and st_ready=1 asynchronously; no st_done pulse.
